// File: rtl/lvg_pkg.sv
// Shared opcodes, FSM states and instruction payload for the lvg matmul sequencer.
package lvg_pkg;

    localparam int unsigned LVG_CNT_W = 6;
    localparam int unsigned OPC_W     = 8;
    localparam int unsigned ADDR_W    = 8;

    localparam logic [OPC_W-1:0] OP_NOP   = 8'd0;
    localparam logic [OPC_W-1:0] OP_LOADL = 8'd1;
    localparam logic [OPC_W-1:0] OP_LOADR = 8'd2;
    localparam logic [OPC_W-1:0] OP_MM    = 8'd3;
    localparam logic [OPC_W-1:0] OP_MMA   = 8'd4;
    localparam logic [OPC_W-1:0] OP_MMR   = 8'd5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        RUN,
        DONE
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OPC_W-1:0]  opcode;
    } instr_t;

endpackage

// File: rtl/lvg_sequencer_if.sv
// Host instruction handshake plus engine control outputs of the lvg sequencer.
interface lvg_sequencer_if #(
    parameter int unsigned CNT_W = lvg_pkg::LVG_CNT_W
) ();

    logic                       instr_valid;
    logic                       instr_ready;
    lvg_pkg::instr_t            instr;
    logic                       load_l;
    logic                       load_r;
    logic                       sys_rst;
    logic [CNT_W-1:0]           sys_count;
    logic [CNT_W-1:0]           dis_count;
    logic [CNT_W-1:0]           agg_count;
    logic                       add_en;
    logic                       act_en;
    logic [lvg_pkg::ADDR_W-1:0] exec_addr;
    logic                       busy;
    logic                       done;
    logic                       err;

    modport master (
        output instr_valid, instr,
        input  instr_ready, load_l, load_r, sys_rst, sys_count, dis_count, agg_count,
        input  add_en, act_en, exec_addr, busy, done, err
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, load_l, load_r, sys_rst, sys_count, dis_count, agg_count,
        output add_en, act_en, exec_addr, busy, done, err
    );

endinterface

// File: rtl/lvg_count_delay.sv
// Two-deep count delay line; tap2_i selects a 2-cycle delay instead of 1 (relu register).
module lvg_count_delay #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tap2_i,
    input  logic [CNT_W-1:0] din_i,
    output logic [CNT_W-1:0] dout_o
);

    logic [CNT_W-1:0] stage_q;
    logic [CNT_W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            dout_q  <= '0;
        end else begin
            stage_q <= din_i;
            dout_q  <= tap2_i ? stage_q : din_i;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/lvg_sequencer.sv
// Central control FSM of the lvg matmul engine: decodes one instruction at a time and
// drives dripper loads, array clear and the array/dispatch/aggregate step counters.
module lvg_sequencer
    import lvg_pkg::*;
#(
    parameter int unsigned CNT_W   = LVG_CNT_W,
    parameter int unsigned DIM     = 4,
    parameter int unsigned SYS_LAT = 5
) (
    input logic           clk,
    input logic           rst,
    lvg_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DIS_LO   = CNT_W'(SYS_LAT);
    localparam logic [CNT_W-1:0] DIS_HI   = CNT_W'(SYS_LAT + DIM);
    localparam logic [CNT_W-1:0] DIS_OFS  = CNT_W'(SYS_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_MM  = CNT_W'(SYS_LAT + DIM + 1);
    localparam logic [CNT_W-1:0] LAST_MMR = CNT_W'(SYS_LAT + DIM + 2);

    state_e              state_q, state_d;
    logic                load_l_q, load_l_d;
    logic                load_r_q, load_r_d;
    logic                sys_rst_q, sys_rst_d;
    logic [CNT_W-1:0]    sys_count_q, sys_count_d;
    logic [CNT_W-1:0]    dis_count_q, dis_count_d;
    logic                add_en_q, add_en_d;
    logic                act_en_q, act_en_d;
    logic [ADDR_W-1:0]   exec_addr_q, exec_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept_c;
    logic [CNT_W-1:0]    sys_inc_c;
    logic [CNT_W-1:0]    last_step_c;
    logic [CNT_W-1:0]    agg_count;

    assign bus.instr_ready = (state_q == IDLE) && !rst;
    assign accept_c        = bus.instr_valid && bus.instr_ready;
    assign sys_inc_c       = (sys_count_q == CNT_MAX) ? CNT_MAX : sys_count_q + CNT_W'(1);
    // Relu adds one register stage before the aggregator, so the run lasts one cycle longer.
    assign last_step_c     = act_en_q ? LAST_MMR : LAST_MM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            load_l_q    <= 1'b0;
            load_r_q    <= 1'b0;
            sys_rst_q   <= 1'b0;
            sys_count_q <= '0;
            dis_count_q <= '0;
            add_en_q    <= 1'b0;
            act_en_q    <= 1'b0;
            exec_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_l_q    <= load_l_d;
            load_r_q    <= load_r_d;
            sys_rst_q   <= sys_rst_d;
            sys_count_q <= sys_count_d;
            dis_count_q <= dis_count_d;
            add_en_q    <= add_en_d;
            act_en_q    <= act_en_d;
            exec_addr_q <= exec_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_l_d    = 1'b0;
        load_r_d    = 1'b0;
        sys_rst_d   = 1'b0;
        sys_count_d = sys_count_q;
        dis_count_d = '0;
        add_en_d    = add_en_q;
        act_en_d    = act_en_q;
        exec_addr_d = exec_addr_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                sys_count_d = '0;
                add_en_d    = 1'b0;
                act_en_d    = 1'b0;
                if (accept_c) begin
                    exec_addr_d = bus.instr.addr;
                    case (bus.instr.opcode)
                        OP_NOP: ;
                        OP_LOADL: begin
                            state_d  = LOAD;
                            load_l_d = 1'b1;
                        end
                        OP_LOADR: begin
                            state_d  = LOAD;
                            load_r_d = 1'b1;
                        end
                        OP_MM, OP_MMA, OP_MMR: begin
                            state_d     = CLEAR;
                            sys_rst_d   = 1'b1;
                            sys_count_d = CNT_W'(1);
                            add_en_d    = (bus.instr.opcode != OP_MM);
                            act_en_d    = (bus.instr.opcode == OP_MMR);
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            LOAD: state_d = IDLE;
            CLEAR, RUN: begin
                state_d     = RUN;
                sys_count_d = sys_inc_c;
                // Registered dispatch step tracks the array step it will sit beside.
                if ((sys_count_q >= DIS_LO) && (sys_count_q < DIS_HI)) begin
                    dis_count_d = sys_count_q - DIS_OFS;
                end
                if (sys_count_q == last_step_c) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    sys_count_d = '0;
                    dis_count_d = '0;
                    add_en_d    = 1'b0;
                    act_en_d    = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    lvg_count_delay #(
        .CNT_W (CNT_W)
    ) u_agg_delay (
        .clk    (clk),
        .rst    (rst),
        .tap2_i (act_en_q),
        .din_i  (dis_count_q),
        .dout_o (agg_count)
    );

    assign bus.load_l    = load_l_q;
    assign bus.load_r    = load_r_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.sys_count = sys_count_q;
    assign bus.dis_count = dis_count_q;
    assign bus.agg_count = agg_count;
    assign bus.add_en    = add_en_q;
    assign bus.act_en    = act_en_q;
    assign bus.exec_addr = exec_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_lvg_sequencer.sv
// Vector table of per-cycle expected outputs fed through a scoreboard queue, plus a
// hand-timed MMA run measuring done latency and first aggregate step.
module tb_lvg_sequencer;
    import lvg_pkg::*;

    localparam int unsigned CW  = 6;
    localparam int          SL  = 5;
    localparam int          DM  = 4;

    typedef struct packed {
        logic          ready;
        logic          load_l;
        logic          load_r;
        logic          sys_rst;
        logic [CW-1:0] sys_count;
        logic [CW-1:0] dis_count;
        logic [CW-1:0] agg_count;
        logic          add_en;
        logic          act_en;
        logic [7:0]    exec_addr;
        logic          busy;
        logic          done;
        logic          err;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [15:0] ins;
        obs_t        exp;
    } vec_t;

    typedef struct packed {
        int   idx;
        obs_t exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t vq[$];
    sb_t  sb[$];

    lvg_sequencer_if #(.CNT_W(CW)) bus ();

    lvg_sequencer #(
        .CNT_W   (CW),
        .DIM     (DM),
        .SYS_LAT (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.ready     = bus.instr_ready;
        o.load_l    = bus.load_l;
        o.load_r    = bus.load_r;
        o.sys_rst   = bus.sys_rst;
        o.sys_count = bus.sys_count;
        o.dis_count = bus.dis_count;
        o.agg_count = bus.agg_count;
        o.add_en    = bus.add_en;
        o.act_en    = bus.act_en;
        o.exec_addr = bus.exec_addr;
        o.busy      = bus.busy;
        o.done      = bus.done;
        o.err       = bus.err;
        return o;
    endfunction

    function automatic obs_t idle_obs(input logic [7:0] addr);
        obs_t o = '0;
        o.ready     = 1'b1;
        o.exec_addr = addr;
        return o;
    endfunction

    // Expected outputs in cycle k (1..done cycle) of a matmul, straight from the timeline.
    function automatic obs_t mm_exp(input int k, input int op, input logic [7:0] addr);
        obs_t o   = '0;
        int   dly = (op == 5) ? 2 : 1;
        int   dc  = SL + DM + dly + 1;
        o.exec_addr = addr;
        o.busy      = 1'b1;
        o.sys_rst   = (k == 1);
        o.sys_count = (k < dc) ? CW'(k) : '0;
        if (k >= SL + 1 && k <= SL + DM) o.dis_count = CW'(k - SL);
        if (k >= SL + 1 + dly && k <= SL + DM + dly) o.agg_count = CW'(k - SL - dly);
        o.add_en = (op != 3) && (k < dc);
        o.act_en = (op == 5) && (k < dc);
        o.done   = (k == dc);
        return o;
    endfunction

    function automatic void add(input logic r, input logic v, input logic [15:0] ins, input obs_t e);
        vec_t x;
        x.rst   = r;
        x.valid = v;
        x.ins   = ins;
        x.exp   = e;
        vq.push_back(x);
    endfunction

    function automatic void add_mm(input int op, input logic [7:0] addr, input obs_t e0,
                                   input logic hv, input logic [15:0] hins);
        int dc = SL + DM + ((op == 5) ? 2 : 1) + 1;
        add(1'b0, 1'b1, {addr, 8'(op)}, e0);
        for (int k = 1; k <= dc; k++) add(1'b0, hv, hins, mm_exp(k, op, addr));
    endfunction

    always @(negedge clk) begin
        sb_t  e;
        obs_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = sample();
            tests_run++;
            if (a !== e.exp) begin
                tests_failed++;
                $display("FAIL vec%0d: got %h want %h (sys %0d/%0d dis %0d/%0d agg %0d/%0d done %b/%b)",
                         e.idx, a, e.exp, a.sys_count, e.exp.sys_count, a.dis_count, e.exp.dis_count,
                         a.agg_count, e.exp.agg_count, a.done, e.exp.done);
            end
        end
    end

    initial begin
        obs_t e_err;
        sb_t  s;
        int   c;
        int   first_agg;

        rst             = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h0003;
        repeat (3) @(posedge clk);
        #1;

        // Reset held with an MM offered: nothing accepted, everything low.
        add(1'b1, 1'b1, 16'h0003, '0);
        add(1'b1, 1'b1, 16'h0003, '0);
        add(1'b0, 1'b0, 16'h0000, idle_obs(8'h00));
        // LOADL then LOADR offered back-to-back.
        begin
            obs_t l = '0;
            add(1'b0, 1'b1, 16'h1101, idle_obs(8'h00));
            l.load_l = 1'b1; l.busy = 1'b1; l.exec_addr = 8'h11;
            add(1'b0, 1'b1, 16'h2202, l);
            add(1'b0, 1'b1, 16'h2202, idle_obs(8'h11));
            l = '0; l.load_r = 1'b1; l.busy = 1'b1; l.exec_addr = 8'h22;
            add(1'b0, 1'b0, 16'h0000, l);
        end
        add_mm(3, 8'h2A, idle_obs(8'h22), 1'b0, 16'h0000);
        add_mm(4, 8'h12, idle_obs(8'h2A), 1'b0, 16'h0000);
        add_mm(5, 8'h33, idle_obs(8'h12), 1'b0, 16'h0000);
        // Illegal opcode, then MM accepted in the err cycle, second MM held valid throughout.
        add(1'b0, 1'b1, 16'h4407, idle_obs(8'h33));
        e_err = idle_obs(8'h44);
        e_err.err = 1'b1;
        add_mm(3, 8'h55, e_err, 1'b1, 16'h6603);
        add_mm(3, 8'h66, idle_obs(8'h55), 1'b0, 16'h0000);
        // Reset in cycle 7 of an MM aborts it; no done afterwards.
        add(1'b0, 1'b1, 16'h7703, idle_obs(8'h66));
        for (int k = 1; k <= 6; k++) add(1'b0, 1'b0, 16'h0000, mm_exp(k, 3, 8'h77));
        add(1'b1, 1'b0, 16'h0000, mm_exp(7, 3, 8'h77));
        for (int k = 8; k <= 12; k++) add(1'b0, 1'b0, 16'h0000, idle_obs(8'h00));
        add_mm(3, 8'h78, idle_obs(8'h00), 1'b0, 16'h0000);
        add(1'b0, 1'b0, 16'h0000, idle_obs(8'h78));

        for (int i = 0; i < vq.size(); i++) begin
            rst             = vq[i].rst;
            bus.instr_valid = vq[i].valid;
            bus.instr       = vq[i].ins;
            s.idx = i;
            s.exp = vq[i].exp;
            sb.push_back(s);
            @(posedge clk);
            #1;
        end
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        @(negedge clk);

        // Hand-timed MMA: done must land in cycle 11, first aggregate step in cycle 7.
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h0904;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        c         = 1;
        first_agg = 0;
        while (c <= 40 && bus.done !== 1'b1) begin
            if (first_agg == 0 && bus.agg_count != '0) first_agg = c;
            @(posedge clk);
            #1;
            c++;
        end
        tests_run++;
        if (c != 11) begin
            tests_failed++;
            $display("FAIL mma_done_cycle: got %0d want 11", c);
        end
        tests_run++;
        if (first_agg != 7) begin
            tests_failed++;
            $display("FAIL mma_first_agg: got %0d want 7", first_agg);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.instr_ready !== 1'b1 || bus.exec_addr !== 8'h09) begin
            tests_failed++;
            $display("FAIL mma_back_idle: busy %b ready %b addr %h want 0 1 09",
                     bus.busy, bus.instr_ready, bus.exec_addr);
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lvg_sequencer.md
Name: lvg_sequencer

Overview:
- Central control FSM for the lvg matmul engine. Accepts 16-bit instructions over a valid/ready handshake.
- Sequences the two drippers, the systolic array, the dispatcher, relu and the aggregator by driving their load strobes, the array reset and the step counters.
- Replaces ad-hoc counter logic in the top level. One instruction executes at a time; busy and done report progress to the host.

Parameters:
- CNT_W, 6, width of sys_count/dis_count/agg_count.
- DIM, 4, array dimension; number of dispatch and aggregate steps.
- SYS_LAT, 5, sys_count value after which the first systolic result is valid.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept; combinational = (state==IDLE) & ~rst.
- instr  in  16  [7:0] opcode, [15:8] address.
- load_l  out  1  one-cycle pulse; left dripper load.
- load_r  out  1  one-cycle pulse; right dripper load.
- sys_rst  out  1  systolic array clear.
- sys_count  out  CNT_W  dripper/array step.
- dis_count  out  CNT_W  dispatcher step; 0 = idle.
- agg_count  out  CNT_W  aggregator step; 0 = idle.
- add_en  out  1  dispatcher adds bias operand.
- act_en  out  1  relu enable; aggregator takes relu path.
- exec_addr  out  8  address of the current instruction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of a matmul.
- err  out  1  one-cycle pulse on illegal opcode.

Behaviour:
- Reset: state IDLE; every registered output 0; instr_ready 0 while rst is high.
- Reset mid-operation aborts the sequence and cancels any pending done.
- Accept = instr_valid & instr_ready at a rising edge; call that edge cycle 0. exec_addr latches instr[15:8] on every accept.
- Opcodes:
  - 0 NOP: consumed, no effect.
  - 1 LOADL / 2 LOADR: state LOAD for cycle 1; load_l or load_r = 1 in cycle 1 only; ready 0 in cycle 1; back in IDLE in cycle 2.
  - 3 MM: plain matmul; add_en=0, act_en=0.
  - 4 MMA: matmul with add; add_en=1 for the whole run.
  - 5 MMR: matmul with add and relu; add_en=1 and act_en=1 for the whole run.
  - 6..255: err=1 in cycle 1, no other effect, ready stays 1.
- Matmul run (MM/MMA/MMR). States: CLEAR -> RUN -> DONE -> IDLE.
  - Cycle 1 (CLEAR): sys_rst=1, sys_count=1.
  - From cycle 2 (RUN): sys_rst=0; sys_count increments each cycle, saturating at 2^CNT_W-1.
  - dis_count = k-SYS_LAT in cycles k = SYS_LAT+1 .. SYS_LAT+DIM; 0 otherwise.
  - agg_count = dis_count delayed by AGG_DLY cycles. AGG_DLY=1 for MM/MMA, 2 for MMR (relu register).
  - DONE: done=1 in cycle SYS_LAT+DIM+AGG_DLY+1. In that cycle all counts, add_en and act_en return to 0.
  - State returns to IDLE the next cycle; ready=1 there.
- Defaults (SYS_LAT=5, DIM=4):
  - MM: dis 1..4 in cycles 6..9, agg 1..4 in cycles 7..10, done in cycle 11.
  - MMR: agg 1..4 in cycles 8..11, done in cycle 12.
- instr_valid held high while busy: no accept and no side effects. The instruction is taken in the first IDLE cycle.
- Back-to-back matmuls: the second accept happens in the cycle after done. No overlap.
- Width rule: counts are unsigned CNT_W. Build-time constraint: SYS_LAT+DIM+2 < 2^CNT_W.

Decomposition:
- Package lvg_pkg holds: opcode localparams (OP_NOP, OP_LOADL, OP_LOADR, OP_MM, OP_MMA, OP_MMR), the state enum (IDLE, LOAD, CLEAR, RUN, DONE) and the default CNT_W.
- One sub-module, lvg_count_delay: a 2-deep count shift register with a tap select, producing agg_count from dis_count.

Test Plan:
- Reset with instr_valid=1, instr=0x0003 -> no accept; every output 0 and ready=0 while rst is high; ready=1 on the first cycle after rst drops.
- LOADL then LOADR offered back-to-back -> load_l pulse in cycle 1; ready 0 in cycle 1; LOADR accepted in cycle 2; load_r pulse in cycle 3; no other outputs toggle.
- instr=0x2A03 (MM) -> exec_addr=0x2A; sys_rst only in cycle 1; dis_count 1,2,3,4 in cycles 6..9; agg_count 1..4 in cycles 7..10; done in cycle 11; busy in cycles 1..11.
- MMR -> add_en=1 and act_en=1 in cycles 1..11; agg_count 1..4 in cycles 8..11; done in cycle 12; all 0 in cycle 12.
- Opcode 0x07, then an MM held valid -> err pulse in cycle 1 only; MM accepted in cycle 1 and runs; a second MM held valid is accepted only after done.
- rst asserted in cycle 7 of an MM -> all outputs 0 in cycle 8; no done pulse; a new MM after reset runs the full, correct timeline.
